// File: rtl/phoenix_pkg.sv
// Shared RV32I encodings, funct3 codes and the ALU operation set for the phoenix core.
package phoenix_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  // alt selects SUB for ADD and arithmetic for right shifts (instr bit 30).
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/phoenix_alu.sv
// Combinational 32-bit ALU shared by register, immediate and address paths.
module phoenix_alu
  import phoenix_pkg::*;
(
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  alu_op_e    op;
  logic [4:0] shamt;

  assign op    = alu_op_e'(op_i);
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (op)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLT:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'd0, a_i < b_i};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/phoenix_dmem.sv
// Byte-wide little-endian data RAM: 4-byte combinational read, byte-enabled write on clk.
module phoenix_dmem #(
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clk_i,
  input  logic [ADDRESS_WIDTH-1:0] addr_i,
  input  logic [3:0]               be_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [7:0]               Memory [0:DEPTH-1];
  logic [ADDRESS_WIDTH-1:0] addr1, addr2, addr3;

  // Each byte lane wraps independently at the top of the address space.
  assign addr1 = addr_i + ADDRESS_WIDTH'(1);
  assign addr2 = addr_i + ADDRESS_WIDTH'(2);
  assign addr3 = addr_i + ADDRESS_WIDTH'(3);

  assign rdata_o = {Memory[addr3], Memory[addr2], Memory[addr1], Memory[addr_i]};

  always_ff @(posedge clk_i) begin
    if (be_i[0]) Memory[addr_i] <= wdata_i[7:0];
    if (be_i[1]) Memory[addr1]  <= wdata_i[15:8];
    if (be_i[2]) Memory[addr2]  <= wdata_i[23:16];
    if (be_i[3]) Memory[addr3]  <= wdata_i[31:24];
  end

endmodule

// File: rtl/phoenix_fetch.sv
// Fetch wrapper: turns the PC word index into the current instruction.
module phoenix_fetch #(
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic [ADDRESS_WIDTH-3:0] word_addr_i,
  output logic [31:0]              instr_o
);

  phoenix_imem #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) instruction_memory (
    .word_addr_i(word_addr_i),
    .rdata_o    (instr_o)
  );

endmodule

// File: rtl/phoenix_imem.sv
// Word-indexed instruction ROM with combinational read; contents are loaded from outside.
module phoenix_imem #(
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic [ADDRESS_WIDTH-3:0] word_addr_i,
  output logic [31:0]              rdata_o
);

  localparam int DEPTH = 1 << (ADDRESS_WIDTH - 2);

  logic [31:0] Memory [0:DEPTH-1];

  assign rdata_o = Memory[word_addr_i];

endmodule

// File: rtl/phoenix_lsu.sv
// Load/store wrapper: store byte enables and load sign/zero extension around the data RAM.
module phoenix_lsu
  import phoenix_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clk_i,
  input  logic [ADDRESS_WIDTH-1:0] addr_i,
  input  logic [XLEN-1:0]          wdata_i,
  input  logic [2:0]               funct3_i,
  input  logic                     store_en_i,
  output logic [XLEN-1:0]          load_data_o
);

  logic [3:0]      be;
  logic [XLEN-1:0] raw;

  always_comb begin
    be = 4'b0000;
    if (store_en_i) begin
      case (funct3_i)
        F3_SB:   be = 4'b0001;
        F3_SH:   be = 4'b0011;
        F3_SW:   be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end
  end

  phoenix_dmem #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) data_memory (
    .clk_i  (clk_i),
    .addr_i (addr_i),
    .be_i   (be),
    .wdata_i(wdata_i),
    .rdata_o(raw)
  );

  always_comb begin
    load_data_o = raw;
    case (funct3_i)
      F3_LB:   load_data_o = {{24{raw[7]}}, raw[7:0]};
      F3_LH:   load_data_o = {{16{raw[15]}}, raw[15:0]};
      F3_LBU:  load_data_o = {24'd0, raw[7:0]};
      F3_LHU:  load_data_o = {16'd0, raw[15:0]};
      default: load_data_o = raw;
    endcase
  end

endmodule

// File: rtl/phoenix_regfile.sv
// 32x32 register file: two combinational read ports, one write port, x0 hardwired to zero.
module phoenix_regfile
  import phoenix_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] Registers [0:31];

  // Reads see the pre-edge value, so a same-cycle write is not forwarded.
  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : Registers[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : Registers[raddr2_i];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        Registers[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      Registers[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/phoenix_rv32i_core.sv
// Single-cycle RV32I core; one instruction retires per CLK. Optional PHOENIX_HALT_EN makes
// ECALL/EBREAK freeze PC, registers and memory until the next synchronous reset.
module phoenix_rv32i_core
  import phoenix_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12
) (
  input logic CLK,
  input logic reset
);

  logic [XLEN-1:0] pc_q, pc_d, pc_next, pc_plus4;
  logic            halted_q, halted_d, halt_req, run;
  logic [31:0]     instr;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rs1_a, rs2_a, rd_a;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_dat, rs2_dat, alu_b, alu_res, ld_dat, wb_dat;
  alu_op_e         alu_op;
  logic            wb_en, st_req, br_taken, ld_ok, st_ok, imm_ok, reg_ok;

  assign opcode = instr[6:0];
  assign rd_a   = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1_a  = instr[19:15];
  assign rs2_a  = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign pc_plus4 = pc_q + 32'd4;

  assign ld_ok  = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  assign st_ok  = funct3 inside {F3_SB, F3_SH, F3_SW};
  assign imm_ok = (funct3 == F3_SLL) ? (funct7 == F7_BASE) :
                  (funct3 == F3_SR)  ? (funct7 == F7_BASE || funct7 == F7_ALT) : 1'b1;
  assign reg_ok = (funct7 == F7_BASE) ||
                  (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR));

`ifdef PHOENIX_HALT_EN
  // ECALL (imm 0) and EBREAK (imm 1) differ only in bit 20.
  assign halt_req = (opcode == OP_SYSTEM) && (funct3 == 3'b000) &&
                    (instr[31:21] == 11'd0) && (instr[19:7] == 13'd0);
`else
  assign halt_req = 1'b0;
`endif

  assign run      = reset & ~halted_q & ~halt_req;
  assign halted_d = halted_q | halt_req;
  assign pc_d     = run ? pc_next : pc_q;

  phoenix_fetch #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) fetch_unit (
    .word_addr_i(pc_q[ADDRESS_WIDTH-1:2]),
    .instr_o    (instr)
  );

  phoenix_regfile register_file (
    .clk_i   (CLK),
    .rst_ni  (reset),
    .raddr1_i(rs1_a),
    .raddr2_i(rs2_a),
    .rdata1_o(rs1_dat),
    .rdata2_o(rs2_dat),
    .we_i    (wb_en & run),
    .waddr_i (rd_a),
    .wdata_i (wb_dat)
  );

  phoenix_alu alu (
    .op_i    (alu_op),
    .a_i     (rs1_dat),
    .b_i     (alu_b),
    .result_o(alu_res)
  );

  phoenix_lsu #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) load_store_unit (
    .clk_i      (CLK),
    .addr_i     (alu_res[ADDRESS_WIDTH-1:0]),
    .wdata_i    (rs2_dat),
    .funct3_i   (funct3),
    .store_en_i (st_req & run),
    .load_data_o(ld_dat)
  );

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1_dat == rs2_dat);
      F3_BNE:  br_taken = (rs1_dat != rs2_dat);
      F3_BLT:  br_taken = ($signed(rs1_dat) < $signed(rs2_dat));
      F3_BGE:  br_taken = ($signed(rs1_dat) >= $signed(rs2_dat));
      F3_BLTU: br_taken = (rs1_dat < rs2_dat);
      F3_BGEU: br_taken = (rs1_dat >= rs2_dat);
      default: br_taken = 1'b0;
    endcase
  end

  // Anything not decoded below (FENCE, SYSTEM, bad encodings) falls through as a NOP.
  always_comb begin
    wb_en   = 1'b0;
    st_req  = 1'b0;
    alu_op  = ALU_ADD;
    alu_b   = imm_i;
    wb_dat  = alu_res;
    pc_next = pc_plus4;
    case (opcode)
      OP_LUI: begin
        wb_en  = 1'b1;
        wb_dat = imm_u;
      end
      OP_AUIPC: begin
        wb_en  = 1'b1;
        wb_dat = pc_q + imm_u;
      end
      OP_JAL: begin
        wb_en   = 1'b1;
        wb_dat  = pc_plus4;
        pc_next = pc_q + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          wb_en   = 1'b1;
          wb_dat  = pc_plus4;
          pc_next = {alu_res[XLEN-1:1], 1'b0};
        end
      end
      OP_BRANCH: begin
        if (br_taken) pc_next = pc_q + imm_b;
      end
      OP_LOAD: begin
        wb_en  = ld_ok;
        wb_dat = ld_dat;
      end
      OP_STORE: begin
        alu_b  = imm_s;
        st_req = st_ok;
      end
      OP_IMM: begin
        alu_op = alu_decode(funct3, (funct3 == F3_SR) && instr[30]);
        wb_en  = imm_ok;
      end
      OP_REG: begin
        alu_b  = rs2_dat;
        alu_op = alu_decode(funct3, instr[30]);
        wb_en  = reg_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_phoenix_rv32i_core.sv
// Directed bench for phoenix_rv32i_core: hand-assembled programs with hand-computed results.
module tb_phoenix_rv32i_core;

  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] IMM   = 7'b0010011;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam int IMEM_WORDS    = 1024;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [31:0] prog [$];

  phoenix_rv32i_core #(.ADDRESS_WIDTH(12)) dut (.CLK(CLK), .reset(reset));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] i_t(input int imm, input int rs1, input logic [2:0] f3,
                                      input int rd, input logic [6:0] op);
    logic [11:0] im;
    im = imm[11:0];
    return {im, 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1,
                                      input logic [2:0] f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
    logic [11:0] im;
    im = imm[11:0];
    return {im[11:5], 5'(rs2), 5'(rs1), f3, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
    logic [12:0] im;
    im = imm[12:0];
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] u_t(input int imm20, input int rd, input logic [6:0] op);
    logic [19:0] im;
    im = imm20[19:0];
    return {im, 5'(rd), op};
  endfunction

  function automatic logic [31:0] j_t(input int imm, input int rd);
    logic [20:0] im;
    im = imm[20:0];
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic logic [31:0] rg(input int i);
    return dut.register_file.Registers[i];
  endfunction

  function automatic logic [7:0] mb(input int a);
    return dut.load_store_unit.data_memory.Memory[a];
  endfunction

  function automatic logic [31:0] mw(input int a);
    return {mb(a + 3), mb(a + 2), mb(a + 1), mb(a)};
  endfunction

  task automatic run(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic load_and_start();
    reset = 1'b0;
    for (int i = 0; i < IMEM_WORDS; i++) begin
      dut.fetch_unit.instruction_memory.Memory[i] = (i < prog.size()) ? prog[i] : NOP;
    end
    run(2);
    @(negedge CLK);
    reset = 1'b1;
  endtask

  initial begin
    // ALU, x0 and NOP-class encodings
    prog = '{i_t(-1, 0, 3'b000, 1, IMM), i_t(28, 1, 3'b101, 2, IMM),
             i_t(1024 + 28, 1, 3'b101, 3, IMM), r_t(0, 1, 0, 3'b011, 4),
             i_t(5, 0, 3'b000, 0, IMM), r_t(0, 2, 1, 3'b000, 6), r_t(32, 1, 2, 3'b000, 7),
             r_t(0, 2, 1, 3'b010, 8), u_t(20'h12345, 9, LUI), u_t(1, 10, AUIPC),
             32'hFFFFFFFF, 32'h00000A0F};
    load_and_start();
    chk("pc_in_reset", dut.pc_q, 32'h0);
    run(1);
    chk("pc_first_fetch", dut.pc_q, 32'h4);
    chk("addi_neg1", rg(1), 32'hFFFFFFFF);
    run(11);
    chk("srli", rg(2), 32'h0000000F);
    chk("srai", rg(3), 32'hFFFFFFFF);
    chk("sltu", rg(4), 32'h00000001);
    chk("x0_write", rg(0), 32'h0);
    chk("add_wrap", rg(6), 32'h0000000E);
    chk("sub", rg(7), 32'h00000010);
    chk("slt", rg(8), 32'h00000001);
    chk("lui", rg(9), 32'h12345000);
    chk("auipc", rg(10), 32'h00001024);
    chk("fence_nop", rg(20), 32'h0);
    chk("bad_op_nop", rg(31), 32'h0);
    chk("pc_after_alu", dut.pc_q, 32'd48);

    // Mid-run reset with live register contents
    reset = 1'b0;
    run(3);
    chk("pc_reset", dut.pc_q, 32'h0);
    for (int i = 1; i < 32; i++) begin
      chk($sformatf("reset_x%0d", i), rg(i), 32'h0);
    end

    // Loads/stores: extension, misalignment, address wrap
    prog = '{u_t(20'h11223, 1, LUI), i_t(12'h344, 1, 3'b000, 1, IMM),
             i_t(256, 0, 3'b000, 2, IMM), s_t(0, 1, 2, 3'b010),
             i_t(1, 2, 3'b000, 3, LOAD), i_t(3, 2, 3'b100, 4, LOAD), i_t(2, 2, 3'b001, 5, LOAD),
             i_t(-128, 0, 3'b000, 8, IMM), s_t(4, 8, 2, 3'b000),
             i_t(4, 2, 3'b000, 9, LOAD), i_t(4, 2, 3'b100, 10, LOAD), i_t(1, 2, 3'b010, 11, LOAD),
             s_t(6, 8, 2, 3'b001), i_t(6, 2, 3'b101, 12, LOAD), i_t(6, 2, 3'b001, 13, LOAD),
             i_t(-1, 0, 3'b000, 14, IMM), s_t(0, 1, 14, 3'b010), i_t(0, 14, 3'b010, 15, LOAD)};
    load_and_start();
    run(18);
    chk("lb_101", rg(3), 32'h00000033);
    chk("lbu_103", rg(4), 32'h00000011);
    chk("lh_102", rg(5), 32'h00001122);
    chk("mem_100", {24'd0, mb(32'h100)}, 32'h44);
    chk("mem_101", {24'd0, mb(32'h101)}, 32'h33);
    chk("mem_102", {24'd0, mb(32'h102)}, 32'h22);
    chk("mem_103", {24'd0, mb(32'h103)}, 32'h11);
    chk("lb_neg", rg(9), 32'hFFFFFF80);
    chk("lbu_80", rg(10), 32'h00000080);
    chk("lw_misaligned", rg(11), 32'h80112233);
    chk("lhu_ff80", rg(12), 32'h0000FF80);
    chk("lh_ff80", rg(13), 32'hFFFFFF80);
    chk("lw_wrap", rg(15), 32'h11223344);
    chk("mem_fff", {24'd0, mb(32'hFFF)}, 32'h44);
    chk("mem_002_wrap", {24'd0, mb(32'h002)}, 32'h11);

    // Control flow: loop, JAL link, JALR back with odd target, branch variants
    prog = '{i_t(10, 0, 3'b000, 1, IMM), i_t(0, 0, 3'b000, 2, IMM),
             i_t(1, 2, 3'b000, 2, IMM), i_t(-1, 1, 3'b000, 1, IMM), b_t(-8, 0, 1, 3'b001),
             j_t(8, 3), i_t(3, 4, 3'b000, 4, IMM), i_t(1, 5, 3'b000, 5, IMM),
             i_t(2, 0, 3'b000, 6, IMM), b_t(12, 6, 5, 3'b101), i_t(1, 3, 3'b000, 3, IMM),
             i_t(0, 3, 3'b000, 0, JALR), i_t(61, 0, 3'b000, 12, IMM),
             i_t(0, 12, 3'b000, 13, JALR), i_t(1, 0, 3'b000, 14, IMM),
             i_t(-1, 0, 3'b000, 11, IMM), b_t(8, 12, 11, 3'b110), i_t(1, 0, 3'b000, 16, IMM),
             b_t(8, 12, 11, 3'b100), i_t(1, 0, 3'b000, 17, IMM), b_t(8, 12, 11, 3'b111),
             i_t(1, 0, 3'b000, 18, IMM), b_t(0, 0, 0, 3'b000)};
    load_and_start();
    run(60);
    chk("loop_counter", rg(1), 32'h0);
    chk("loop_iters", rg(2), 32'd10);
    chk("jal_link_plus1", rg(3), 32'd25);
    chk("jalr_back_path", rg(4), 32'd3);
    chk("bge_visits", rg(5), 32'd2);
    chk("jalr_link", rg(13), 32'd56);
    chk("jalr_skip", rg(14), 32'h0);
    chk("bltu_not_taken", rg(16), 32'd1);
    chk("blt_taken", rg(17), 32'h0);
    chk("bgeu_taken", rg(18), 32'h0);
    chk("pc_final_loop", dut.pc_q, 32'd88);

    // Fibonacci F(0..19) stored as words from 0x000
    prog = '{i_t(0, 0, 3'b000, 1, IMM), i_t(1, 0, 3'b000, 2, IMM), i_t(0, 0, 3'b000, 3, IMM),
             i_t(80, 0, 3'b000, 4, IMM), s_t(0, 1, 3, 3'b010), r_t(0, 2, 1, 3'b000, 5),
             i_t(0, 2, 3'b000, 1, IMM), i_t(0, 5, 3'b000, 2, IMM), i_t(4, 3, 3'b000, 3, IMM),
             b_t(-20, 4, 3, 3'b001), j_t(0, 0)};
    load_and_start();
    run(1000);
    chk("fib_0", mw(32'h00), 32'd0);
    chk("fib_1", mw(32'h04), 32'd1);
    chk("fib_2", mw(32'h08), 32'd1);
    chk("fib_5", mw(32'h14), 32'd5);
    chk("fib_10", mw(32'h28), 32'h37);
    chk("fib_18", mw(32'h48), 32'h0A18);
    chk("fib_19", mw(32'h4C), 32'h1055);

    // EBREAK between two writes of x5
    prog = '{i_t(7, 0, 3'b000, 5, IMM), 32'h00100073, i_t(9, 0, 3'b000, 5, IMM), j_t(0, 0)};
    load_and_start();
    run(10);
`ifdef PHOENIX_HALT_EN
    chk("halt_x5", rg(5), 32'd7);
    chk("halt_pc", dut.pc_q, 32'd4);
    run(5);
    chk("halt_pc_frozen", dut.pc_q, 32'd4);
    reset = 1'b0;
    run(1);
    chk("halt_cleared_pc", dut.pc_q, 32'h0);
    reset = 1'b1;
`else
    chk("ebreak_nop_x5", rg(5), 32'd9);
    chk("ebreak_nop_pc", dut.pc_q, 32'd12);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phoenix_rv32i_core.md
Name: phoenix_rv32i_core

Overview:
- Single-cycle RV32I integer core with internal instruction memory, byte-addressed data memory and a 32x32 register file.
- Top-level simulation/FPGA block: the bench preloads the program with $readmemh and dumps data memory after the run.
- Sub-instance hierarchy is fixed for bench access: register_file.Registers[0..31], fetch_unit.instruction_memory.Memory[], load_store_unit.data_memory.Memory[].

Parameters:
- ADDRESS_WIDTH, 12, byte-address width of both memories (2^ADDRESS_WIDTH bytes each).

Ports:
- CLK  input  1  single core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising CLK).
- Interface decision: one clock; reset is synchronous and active-low. There is no separate memory clock and there are no other ports.

Behaviour:
- Reset (reset==0 at rising CLK): PC<=0; Registers[0..31]<=0; halted flag<=0. Memory contents are not cleared, so the preloaded program survives.
- Reset mid-run: the next rising edge with reset==0 restarts from PC=0. No partial write occurs in that cycle.
- Instruction memory:
  - 32-bit words, depth 2^(ADDRESS_WIDTH-2), word-indexed (Memory[i] holds byte address 4i).
  - Combinational read at PC[ADDRESS_WIDTH-1:2]; PC[1:0] is ignored.
- Data memory:
  - 8-bit array, depth 2^ADDRESS_WIDTH, little-endian.
  - Combinational read, write on rising CLK.
  - Effective address uses the low ADDRESS_WIDTH bits; byte addresses wrap modulo 2^ADDRESS_WIDTH per byte.
  - Misaligned accesses are allowed and assembled bytewise.
- Timing: one instruction retires per CLK cycle after reset deasserts. Register and memory writes and the PC update all occur on the same edge.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target & ~1).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU, with sign or zero extension as specified by RV32I.
  - SB/SH/SW.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Arithmetic: 32-bit wraparound with no overflow trap. Shift amount is the low 5 bits.
- x0 reads 0 always; writes to x0 are discarded.
- Next PC is PC+4, or the branch/jump target (PC-relative, 32-bit wrap). The link value is PC+4.
- FENCE, ECALL, EBREAK and any unrecognised opcode execute as NOP: no register or memory write, PC+4.
- Register file has 2 combinational read ports and 1 write port. A write and a read of the same register in the same cycle return the old value.

Optional Feature:
- Macro PHOENIX_HALT_EN.
- Defined:
  - ECALL or EBREAK sets the halted flag.
  - While halted: PC, registers and memory are frozen; fetch continues but has no effect.
  - Only reset clears the flag.
- Undefined: ECALL/EBREAK are NOPs; the core never halts.

Decomposition:
- Shared package phoenix_pkg holds:
  - Opcode constants (OP_LUI 0110111 … OP_SYSTEM 1110011).
  - funct3 constants for branch, load/store and ALU.
  - An ALU-operation enum.
  - XLEN=32.
- Sub-modules:
  - Natural sub-module: phoenix_alu (op, a, b -> result), shared by ALU-immediate, ALU-register and address paths.
  - Required wrappers for hierarchy: register_file, fetch_unit (containing instruction_memory) and load_store_unit (containing data_memory). Each is a thin wrapper.

Test Plan:
- Reset: hold reset=0 for 3 cycles with arbitrary register contents -> PC=0, x1..x31=0. Release: the first fetch is at address 0.
- ALU: ADDI x1,x0,-1; SRLI x2,x1,28; SRAI x3,x1,28; SLTU x4,x0,x1 -> x1=FFFFFFFF, x2=0000000F, x3=FFFFFFFF, x4=1. ADDI x0,x0,5 leaves x0=0.
- Memory: SW of 0x11223344 at 0x100, then LB 0x101, LBU 0x103, LH 0x102 -> 00000033, 00000011, 00001122. Memory[0x100..0x103] = 44,33,22,11.
- Control flow: BNE loop of 10 iterations, JAL x1 forward +8, JALR x0,0(x1) back -> correct iteration count. Link = PC+4. The JALR target LSB is cleared.
- Fibonacci program: store F(0..19) as words from 0x000 and run 10000 ns -> the data dump shows 0,1,1,2,3,5,… with 0x1055 at address 0x04C.
- PHOENIX_HALT_EN: EBREAK after ADDI x5,x0,7 followed by ADDI x5,x0,9 -> x5 stays 7 and the PC freezes. Without the macro, x5=9.
